// File: rtl/seq_block_subtractor.sv
`default_nettype none
// ============================================================================
// Module     : seq_block_subtractor
// Purpose    : Block-serial subtractor. Computes (a - b - b_in) mod 2^WIDTH
//              one BLK-bit slice per clock, least-significant slice first,
//              with the inter-slice borrow held in a register. Operands are
//              taken through an in_valid/in_ready handshake and the result
//              is offered through an out_valid/out_ready handshake.
// Ports      : clk        - clock, all state updates on the rising edge
//              rst        - synchronous active-high reset
//              in_valid   - operands valid
//              in_ready   - block can accept operands (IDLE)
//              a, b       - minuend / subtrahend, WIDTH bits
//              b_in       - borrow in
//              out_valid  - result valid (DONE)
//              out_ready  - consumer accepts result
//              diff       - (a - b - b_in) mod 2^WIDTH
//              b_out      - final borrow, 1 iff a < b + b_in (unsigned)
//              ovf        - signed overflow (only when SUB_OVF_EN is defined)
// Options    : SUB_OVF_EN - adds the ovf port and its overflow logic
// Revision   : 1.0 - initial release
// ============================================================================
module seq_block_subtractor #(
  parameter int WIDTH = 5,
  parameter int BLK   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             b_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             b_out
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NBLK = (WIDTH + BLK - 1) / BLK;
  // Operands are zero-padded to a whole number of slices so the last,
  // possibly partial, slice can be selected with a fixed-width part select.
  localparam int WEXT = NBLK * BLK;
  localparam int IW   = (NBLK > 1) ? $clog2(NBLK) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBLK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             borrow_r;
  logic [IW-1:0]    idx_r;

  logic [WEXT-1:0]  a_ext;
  logic [WEXT-1:0]  b_ext;
  logic [BLK-1:0]   a_s;
  logic [BLK-1:0]   b_s;
  logic [BLK:0]     s;
  logic [WIDTH-1:0] diff_nxt;

  assign a_ext = WEXT'(a_r);
  assign b_ext = WEXT'(b_r);
  assign a_s   = a_ext[int'(idx_r) * BLK +: BLK];
  assign b_s   = b_ext[int'(idx_r) * BLK +: BLK];

  // Slice subtraction with one extra bit to capture the borrow. In a partial
  // last slice the padding bits are zero in both operands, so s[BLK] equals
  // the borrow out of that slice's own top valid bit.
  assign s = {1'b0, a_s} - {1'b0, b_s} - {{BLK{1'b0}}, borrow_r};

  // Merge the current slice result into the running difference. Padding
  // result bits above WIDTH-1 are simply never written.
  always_comb begin
    diff_nxt = diff;
    for (int j = 0; j < WIDTH; j++) begin
      if ((j / BLK) == int'(idx_r)) begin
        diff_nxt[j] = s[j % BLK];
      end
    end
  end

`ifdef SUB_OVF_EN
  logic ovf_nxt;
  // Signed overflow: operands of opposite sign and result sign differs from a.
  assign ovf_nxt = (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (diff_nxt[WIDTH-1] ^ a_r[WIDTH-1]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      diff      <= '0;
      b_out     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      borrow_r  <= 1'b0;
      idx_r     <= '0;
`ifdef SUB_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= b_in;
            idx_r    <= '0;
            diff     <= '0;
            b_out    <= 1'b0;
            in_ready <= 1'b0;
`ifdef SUB_OVF_EN
            ovf      <= 1'b0;
`endif
            state    <= CALC;
          end
        end

        CALC: begin
          diff     <= diff_nxt;
          borrow_r <= s[BLK];
          if (idx_r == LAST_IDX) begin
            idx_r     <= '0;
            b_out     <= s[BLK];
            out_valid <= 1'b1;
`ifdef SUB_OVF_EN
            ovf       <= ovf_nxt;
`endif
            state     <= DONE;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end

        DONE: begin
          // Return to IDLE only; a new operand can be taken the cycle after.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_block_subtractor.sv
`default_nettype none
// ============================================================================
// Module     : tb_seq_block_subtractor
// Purpose    : Directed self-checking bench for seq_block_subtractor. Three
//              instances: defaults (5/2), partial last slice (8/3) and a
//              single-slice configuration (4/4).
// Options    : SUB_OVF_EN - also checks the ovf outputs
// Revision   : 1.0 - initial release
// ============================================================================
module tb_seq_block_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Default instance
  logic       iv5 = 0, ir5, ov5, or5 = 0, bi5 = 0, bo5, ovf5;
  logic [4:0] a5 = 0, b5 = 0, d5;
  // Partial-last-slice instance
  logic       iv8 = 0, ir8, ov8, or8 = 0, bi8 = 0, bo8, ovf8;
  logic [7:0] a8 = 0, b8 = 0, d8;
  // Single-slice instance
  logic       iv4 = 0, ir4, ov4, or4 = 0, bi4 = 0, bo4, ovf4;
  logic [3:0] a4 = 0, b4 = 0, d4;

  seq_block_subtractor #(.WIDTH(5), .BLK(2)) dut5 (
    .clk(clk), .rst(rst), .in_valid(iv5), .in_ready(ir5), .a(a5), .b(b5),
    .b_in(bi5), .out_valid(ov5), .out_ready(or5), .diff(d5), .b_out(bo5)
`ifdef SUB_OVF_EN
    , .ovf(ovf5)
`endif
  );

  seq_block_subtractor #(.WIDTH(8), .BLK(3)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .b_in(bi8), .out_valid(ov8), .out_ready(or8), .diff(d8), .b_out(bo8)
`ifdef SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  seq_block_subtractor #(.WIDTH(4), .BLK(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .b_in(bi4), .out_valid(ov4), .out_ready(or4), .diff(d4), .b_out(bo4)
`ifdef SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef SUB_OVF_EN
  assign ovf5 = 1'b0;
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  // Drive one operand set into dut5; operands are scrambled afterwards so
  // any late sampling shows up as a wrong result.
  task automatic send5(input logic [4:0] av, input logic [4:0] bv, input logic bi);
    @(negedge clk);
    a5 = av; b5 = bv; bi5 = bi; iv5 = 1'b1;
    @(posedge clk); #1;
    iv5 = 1'b0; a5 = 5'($urandom); b5 = 5'($urandom); bi5 = 1'($urandom);
  endtask

  // Count edges from acceptance until out_valid, bounded at 20.
  task automatic wait5(output int lat);
    lat = 0;
    while (!ov5 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    vectors++;
    if (ir5 !== 1'b1 || ov5 !== 1'b0 || d5 !== 5'd0 || bo5 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset5: in_ready=%b out_valid=%b diff=%b b_out=%b, want 1 0 00000 0", ir5, ov5, d5, bo5);
    end
    vectors++;
    if (ir8 !== 1'b1 || ov8 !== 1'b0 || d8 !== 8'd0 || bo8 !== 1'b0 || ir4 !== 1'b1 || ov4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset8_4: ir8=%b ov8=%b d8=%h bo8=%b ir4=%b ov4=%b, want 1 0 00 0 1 0", ir8, ov8, d8, bo8, ir4, ov4);
    end
`ifdef SUB_OVF_EN
    vectors++;
    if (ovf5 !== 1'b0 || ovf8 !== 1'b0 || ovf4 !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ovf: ovf5=%b ovf8=%b ovf4=%b, want 0", ovf5, ovf8, ovf4);
    end
`endif
  endtask

  task automatic test_basic;
    logic [4:0] ta [4] = '{5'b10111, 5'b00101, 5'b11111, 5'b01111};
    logic [4:0] tb [4] = '{5'b00101, 5'b10111, 5'b11111, 5'b10000};
    logic       tbi[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [4:0] ed [4] = '{5'b10010, 5'b01110, 5'b11111, 5'b11111};
    logic       eb [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic       eo [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ir5 !== 1'b1) begin
        miscompares++;
        $display("FAIL basic%0d_ready: in_ready=%b, want 1", i, ir5);
      end
      send5(ta[i], tb[i], tbi[i]);
      wait5(lat);
      vectors++;
      if (lat !== 3) begin
        miscompares++;
        $display("FAIL basic%0d_latency: got %0d cycles, want 3", i, lat);
      end
      vectors++;
      if (d5 !== ed[i] || bo5 !== eb[i]) begin
        miscompares++;
        $display("FAIL basic%0d_result: diff=%b b_out=%b, want %b %b", i, d5, bo5, ed[i], eb[i]);
      end
`ifdef SUB_OVF_EN
      vectors++;
      if (ovf5 !== eo[i]) begin
        miscompares++;
        $display("FAIL basic%0d_ovf: ovf=%b, want %b", i, ovf5, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unreachable");
`endif
      @(negedge clk); or5 = 1'b1;
      @(posedge clk); #1; or5 = 1'b0;
      vectors++;
      if (ir5 !== 1'b1 || ov5 !== 1'b0) begin
        miscompares++;
        $display("FAIL basic%0d_handoff: in_ready=%b out_valid=%b, want 1 0", i, ir5, ov5);
      end
    end
  endtask

  task automatic test_back_pressure;
    int lat;
    int bad = 0;
    send5(5'b10111, 5'b00101, 1'b0);
    wait5(lat);
    // New operands offered while DONE is held must be ignored.
    @(negedge clk); iv5 = 1'b1; a5 = 5'b00000; b5 = 5'b11111; bi5 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ov5 !== 1'b1 || d5 !== 5'b10010 || bo5 !== 1'b0 || ir5 !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL hold: %0d of 10 cycles changed (out_valid=%b diff=%b in_ready=%b), want held 1 10010 0", bad, ov5, d5, ir5);
    end
    // in_valid still high at the handoff edge: must not be accepted there.
    @(negedge clk); or5 = 1'b1;
    @(posedge clk); #1; or5 = 1'b0; iv5 = 1'b0;
    vectors++;
    if (ir5 !== 1'b1 || ov5 !== 1'b0) begin
      miscompares++;
      $display("FAIL release: in_ready=%b out_valid=%b, want 1 0", ir5, ov5);
    end
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (ir5 !== 1'b1 || ov5 !== 1'b0) begin
      miscompares++;
      $display("FAIL no_accept_at_handoff: in_ready=%b out_valid=%b, want 1 0", ir5, ov5);
    end
  endtask

  task automatic test_mid_reset;
    int lat;
    int bad = 0;
    send5(5'b10111, 5'b00101, 1'b0);
    @(posedge clk); #1;             // now in the 2nd CALC cycle
    rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    vectors++;
    if (ir5 !== 1'b1 || ov5 !== 1'b0 || d5 !== 5'd0 || bo5 !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: in_ready=%b out_valid=%b diff=%b b_out=%b, want 1 0 00000 0", ir5, ov5, d5, bo5);
    end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (ov5 !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_output: out_valid seen %0d times, want 0", bad);
    end
    send5(5'b00000, 5'b00000, 1'b0);
    wait5(lat);
    vectors++;
    if (lat !== 3 || d5 !== 5'b00000 || bo5 !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_op: lat=%0d diff=%b b_out=%b, want 3 00000 0", lat, d5, bo5);
    end
    @(negedge clk); or5 = 1'b1;
    @(posedge clk); #1; or5 = 1'b0;
  endtask

  task automatic test_partial_slice;
    logic [7:0] ta [2] = '{8'h00, 8'hA5};
    logic [7:0] tb [2] = '{8'h01, 8'h3C};
    logic       tbi[2] = '{1'b0, 1'b1};
    logic [7:0] ed [2] = '{8'hFF, 8'h68};
    logic       eb [2] = '{1'b1, 1'b0};
    logic       eo [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); a8 = ta[i]; b8 = tb[i]; bi8 = tbi[i]; iv8 = 1'b1;
      @(posedge clk); #1; iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      lat = 0;
      while (!ov8 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      vectors++;
      if (lat !== 3 || d8 !== ed[i] || bo8 !== eb[i]) begin
        miscompares++;
        $display("FAIL partial%0d: lat=%0d diff=%h b_out=%b, want 3 %h %b", i, lat, d8, bo8, ed[i], eb[i]);
      end
`ifdef SUB_OVF_EN
      vectors++;
      if (ovf8 !== eo[i]) begin
        miscompares++;
        $display("FAIL partial%0d_ovf: ovf=%b, want %b", i, ovf8, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unreachable");
`endif
      @(negedge clk); or8 = 1'b1;
      @(posedge clk); #1; or8 = 1'b0;
    end
  endtask

  task automatic test_single_slice;
    logic [3:0] ta [2] = '{4'h3, 4'h9};
    logic [3:0] tb [2] = '{4'h5, 4'h2};
    logic       tbi[2] = '{1'b0, 1'b1};
    logic [3:0] ed [2] = '{4'hE, 4'h6};
    logic       eb [2] = '{1'b1, 1'b0};
    logic       eo [2] = '{1'b0, 1'b1};
    int lat;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); a4 = ta[i]; b4 = tb[i]; bi4 = tbi[i]; iv4 = 1'b1;
      @(posedge clk); #1; iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom);
      lat = 0;
      while (!ov4 && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      vectors++;
      if (lat !== 1 || d4 !== ed[i] || bo4 !== eb[i]) begin
        miscompares++;
        $display("FAIL single%0d: lat=%0d diff=%h b_out=%b, want 1 %h %b", i, lat, d4, bo4, ed[i], eb[i]);
      end
`ifdef SUB_OVF_EN
      vectors++;
      if (ovf4 !== eo[i]) begin
        miscompares++;
        $display("FAIL single%0d_ovf: ovf=%b, want %b", i, ovf4, eo[i]);
      end
`else
      if (eo[i] === 1'bx) $display("unreachable");
`endif
      @(negedge clk); or4 = 1'b1;
      @(posedge clk); #1; or4 = 1'b0;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_pressure();
    test_mid_reset();
    test_partial_slice();
    test_single_slice();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
